// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the byte-addressable data memory LSU:
// RV32I load/store funct3 codes, FSM state encoding and the request payload.
package data_mem_lsu_pkg;

    localparam int unsigned XLEN_W   = 32;
    localparam int unsigned F3_W_BITS = 3;

    // RV32I funct3 codes for loads and stores
    localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
    localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
    localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
    localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
    localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // One captured memory request
    typedef struct packed {
        logic                  we;
        logic [F3_W_BITS-1:0]  funct3;
        logic [XLEN_W-1:0]     addr;
        logic [XLEN_W-1:0]     wdata;
    } lsu_req_t;

endpackage

// File: rtl/data_mem_lsu_lane_align.sv
// Byte-lane steering for RV32I loads/stores (combinational).
// Ports:
//   we, funct3, lane  - access type, size/sign and byte offset addr[1:0]
//   wdata             - raw store data from the datapath
//   word              - memory word currently addressed
//   be, wlane         - per-byte write enables and lane-replicated store data
//   ldata             - extracted and extended load value (0 on error)
//   err               - misaligned access or illegal funct3
module data_mem_lsu_lane_align
    import data_mem_lsu_pkg::*;
(
    input  logic                 we,
    input  logic [F3_W_BITS-1:0] funct3,
    input  logic [1:0]           lane,
    input  logic [XLEN_W-1:0]    wdata,
    input  logic [XLEN_W-1:0]    word,
    output logic [3:0]           be,
    output logic [XLEN_W-1:0]    wlane,
    output logic [XLEN_W-1:0]    ldata,
    output logic                 err
);

    logic [XLEN_W-1:0] shifted;
    logic              misalign;
    logic              illegal;

    // Decode size/sign, steer lanes and extend the loaded value
    always_comb begin
        be       = 4'b0000;
        wlane    = wdata;
        ldata    = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        shifted  = word >> {lane, 3'b000};
        case (funct3)
            F3_B: begin
                be    = 4'b0001 << lane;
                wlane = {4{wdata[7:0]}};
                ldata = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                misalign = lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wlane    = {2{wdata[15:0]}};
                ldata    = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_W: begin
                misalign = (lane != 2'b00);
                be       = 4'b1111;
                ldata    = shifted;
            end
            F3_BU: begin
                illegal = we;
                ldata   = {24'd0, shifted[7:0]};
            end
            F3_HU: begin
                illegal  = we;
                misalign = lane[0];
                ldata    = {16'd0, shifted[15:0]};
            end
            default: illegal = 1'b1;
        endcase
        err = misalign | illegal;
        // An erroneous access neither writes nor returns data
        if (err) begin
            be    = 4'b0000;
            ldata = '0;
        end
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with RV32I load/store semantics and a
// valid/ready request/response handshake with configurable read latency.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   req_valid/req_ready           - request handshake
//   req_we, req_funct3            - store/load and access size/sign
//   req_addr, req_wdata           - byte address (low ADDR_W bits used), store data
//   resp_valid/resp_ready         - response handshake
//   resp_rdata, resp_err          - extended load data, access error flag
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err
);

    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned DEPTH  = 2 ** WORD_W;
    localparam int unsigned CNT_W  = 2;

    logic [XLEN-1:0]   mem [DEPTH];

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    lsu_req_t          req_q, req_d, req_in, act;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              load_now;
    logic [WORD_W-1:0] word_idx;
    logic [XLEN-1:0]   mem_word;
    logic [3:0]        be;
    logic [XLEN-1:0]   wlane;
    logic [XLEN-1:0]   ldata;
    logic              acc_err;
    logic              unused_addr_bits;

    assign req_in = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

    // In IDLE the incoming request is live; afterwards the captured copy is used
    assign act      = (state_q == ST_IDLE) ? req_in : req_q;
    assign word_idx = act.addr[ADDR_W-1:2];
    assign mem_word = mem[word_idx];

    // Address bits above ADDR_W alias and are deliberately ignored
    assign unused_addr_bits = ^act.addr[XLEN-1:ADDR_W];

    data_mem_lsu_lane_align u_align (
        .we     (act.we),
        .funct3 (act.funct3),
        .lane   (act.addr[1:0]),
        .wdata  (act.wdata),
        .word   (mem_word),
        .be     (be),
        .wlane  (wlane),
        .ldata  (ldata),
        .err    (acc_err)
    );

    // Ready is forced low for the whole time reset is held
    assign req_ready  = ready_q & rst;
    assign accept     = req_valid & req_ready;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Next-state and response data
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        load_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d = req_in;
                    cnt_d = '0;
                    if (LATENCY == 1) begin
                        state_d  = ST_RESP;
                        load_now = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(LATENCY - 1)) begin
                    state_d  = ST_RESP;
                    load_now = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Sample the word on the edge that enters RESP
        if (load_now) begin
            rdata_d = (act.we || acc_err) ? '0 : ldata;
            err_d   = acc_err;
        end
        valid_d = (state_d == ST_RESP);
        ready_d = (state_d == ST_IDLE);
    end

    // State and response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Store commit on the accept edge; array contents survive reset
    always_ff @(posedge clk) begin
        if (accept && act.we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        rr1, rv1, re1, rr3, rv3, re3;
    logic [31:0] rd1, rd3;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int checks;
    int failures;

    logic [7:0] model_mem [2][256];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [19];

    data_mem_lsu #(.XLEN(32), .ADDR_W(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(re1)
    );

    data_mem_lsu #(.XLEN(32), .ADDR_W(8), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr3),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv3), .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(re3)
    );

    assign req_ready  = sel ? rr3 : rr1;
    assign resp_valid = sel ? rv3 : rv1;
    assign resp_rdata = sel ? rd3 : rd1;
    assign resp_err   = sel ? re3 : re1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s sel=%0d got=%h exp=%h", name, sel, got, exp);
        end
    endtask

    // Reference: access size and signedness from funct3, then byte arithmetic
    function automatic void model_access(input int s, input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rd, output logic err);
        int size;
        int a;
        logic [31:0] val;
        bit is_signed;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        is_signed = (f3 < 3'd4);
        a = int'(addr % 256);
        rd = 32'd0;
        err = 1'b0;
        if (size == 0 || (we && f3 >= 3'd3) || (a % size) != 0) begin
            err = 1'b1;
        end else if (we) begin
            for (int i = 0; i < size; i++) model_mem[s][a+i] = wdata[8*i +: 8];
        end else begin
            val = 32'd0;
            for (int i = 0; i < size; i++) val = val | (32'(model_mem[s][a+i]) << (8*i));
            if (is_signed && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
            rd = val;
        end
    endfunction

    task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd,
                            input logic exp_err, input int hold);
        int k;
        int lat;
        lat = sel ? 3 : 1;
        @(negedge clk);
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (resp_valid !== 1'b1) chk("req_ready_busy", 32'(req_ready), 32'd0);
        end while (resp_valid !== 1'b1 && k < 20);
        chk("latency", 32'(k), 32'(lat));
        if (resp_valid !== 1'b1) return;
        chk("rdata", resp_rdata, exp_rd);
        chk("err", 32'(resp_err), 32'(exp_err));
        chk("req_ready_resp", 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("valid_hold", 32'(resp_valid), 32'd1);
            chk("rdata_hold", resp_rdata, exp_rd);
            chk("ready_hold", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", 32'(resp_valid), 32'd0);
    endtask

    task automatic model_transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int hold);
        logic [31:0] rd;
        logic e;
        model_access(sel ? 1 : 0, we, f3, addr, wdata, rd, e);
        transact(we, f3, addr, wdata, rd, e, hold);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sel = 1'b0;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

        // Reset hold
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_valid_l1", 32'(rv1), 32'd0);
            chk("rst_ready_l1", 32'(rr1), 32'd0);
            chk("rst_valid_l3", 32'(rv3), 32'd0);
            chk("rst_ready_l3", 32'(rr3), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst_l1", 32'(rr1), 32'd1);
        chk("ready_after_rst_l3", 32'(rr3), 32'd1);

        // Clear both memories so the model starts from known contents
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 64; w++) begin
                transact(1'b1, 3'b010, 32'(w * 4), 32'd0, 32'd0, 1'b0, 0);
                for (int b = 0; b < 4; b++) model_mem[s][w*4+b] = 8'h00;
            end
        end

        // Directed vectors on the single-cycle instance
        tbl[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 3'b010, 32'h10,  32'h0,        32'h0,        1'b0};
        tbl[3]  = '{1'b1, 3'b000, 32'h13,  32'h80,       32'h0,        1'b0};
        tbl[4]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
        tbl[5]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h00000080, 1'b0};
        tbl[6]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h80000000, 1'b0};
        tbl[7]  = '{1'b0, 3'b001, 32'h11,  32'h0,        32'h0,        1'b1};
        tbl[8]  = '{1'b1, 3'b010, 32'h12,  32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h80000000, 1'b0};
        tbl[10] = '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF8000, 1'b0};
        tbl[11] = '{1'b0, 3'b101, 32'h12,  32'h0,        32'h00008000, 1'b0};
        tbl[12] = '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1};
        tbl[13] = '{1'b1, 3'b100, 32'h10,  32'h55,       32'h0,        1'b1};
        tbl[14] = '{1'b1, 3'b011, 32'h10,  32'h55,       32'h0,        1'b1};
        tbl[15] = '{1'b0, 3'b010, 32'h110, 32'h0,        32'h80000000, 1'b0};
        tbl[16] = '{1'b1, 3'b001, 32'h22,  32'hABCD1234, 32'h0,        1'b0};
        tbl[17] = '{1'b0, 3'b010, 32'h20,  32'h0,        32'h12340000, 1'b0};
        tbl[18] = '{1'b0, 3'b110, 32'h20,  32'h0,        32'h0,        1'b1};
        sel = 1'b0;
        for (int i = 0; i < 19; i++) begin
            logic [31:0] mrd;
            logic me;
            model_access(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mrd, me);
            transact(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err, 0);
        end

        // Multi-cycle latency with a stalled consumer
        sel = 1'b1;
        model_transact(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 0);
        model_transact(1'b0, 3'b010, 32'h40, 32'h0, 5);
        model_transact(1'b0, 3'b001, 32'h42, 32'h0, 5);

        // Reset while waiting: store sticks, response is dropped
        begin
            logic [31:0] mrd;
            logic me;
            @(negedge clk);
            chk("ready_pre_rst", 32'(req_ready), 32'd1);
            req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h1234;
            req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            model_access(1, 1'b1, 3'b010, 32'h20, 32'h1234, mrd, me);
            @(negedge clk);
            rst = 1'b0;
            chk("ready_in_rst", 32'(req_ready), 32'd0);
            @(negedge clk);
            @(negedge clk);
            chk("valid_in_rst", 32'(resp_valid), 32'd0);
            rst = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
            end
            transact(1'b0, 3'b010, 32'h20, 32'h0, 32'h00001234, 1'b0, 0);
        end

        // Randomised traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            sel = 1'($urandom_range(0, 1));
            a = $urandom();
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            model_transact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                           $urandom(), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
